// File: rtl/cpu_pkg.sv
// Shared datapath constants for the writeback/register-bank slice.
// Also defines the write-source tag used by the writeback mux.
package cpu_pkg;

  localparam int CPU_DATA_W   = 16;
  localparam int CPU_NUM_REGS = 16;
  localparam int ZERO_IDX     = 0;

  // Register index width; never narrower than one bit.
  function automatic int cpu_addr_w(input int num_regs);
    return (num_regs > 2) ? $clog2(num_regs) : 1;
  endfunction

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_HOLD,
    SRC_MEM
  } wb_src_e;

endpackage

// File: rtl/wb_hold_buf.sv
// One-entry skid buffer for a MEM writeback that lost arbitration to the ALU.
// Load takes priority; drain and invalidate both empty the entry.
module wb_hold_buf #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_rd,
  input  logic [DATA_W-1:0] load_data,
  input  logic              drain,
  input  logic              invalidate,
  output logic              full,
  output logic [ADDR_W-1:0] rd,
  output logic [DATA_W-1:0] data
);

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    rd_d    = rd_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      rd_d    = load_rd;
      data_d  = load_data;
    end else if (drain || invalidate) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      rd_q    <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
    end
  end

  assign full = valid_q;
  assign rd   = rd_q;
  assign data = data_q;

endmodule

// File: rtl/wb_regfile_demux.sv
// Writeback demux and register bank: merges ALU and MEM writebacks through a
// one-entry hold buffer and keeps a per-register busy scoreboard for issue.
module wb_regfile_demux
  import cpu_pkg::*;
#(
  parameter int DATA_W   = CPU_DATA_W,
  parameter int NUM_REGS = CPU_NUM_REGS,
  parameter int ADDR_W   = cpu_addr_w(NUM_REGS),
  parameter int ZERO_REG = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         iss_valid,
  input  logic [ADDR_W-1:0]            iss_rd,
  input  logic                         a_valid,
  input  logic [ADDR_W-1:0]            a_rd,
  input  logic [DATA_W-1:0]            a_data,
  input  logic                         m_valid,
  output logic                         m_ready,
  input  logic [ADDR_W-1:0]            m_rd,
  input  logic [DATA_W-1:0]            m_data,
  output logic [NUM_REGS*DATA_W-1:0]   regs,
  output logic [NUM_REGS-1:0]          busy
);

  logic              hold_full;
  logic [ADDR_W-1:0] hold_rd;
  logic [DATA_W-1:0] hold_data;
  logic              hold_load, hold_drain, hold_inval;
  logic              m_xfer;
  wb_src_e           wr_src;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_rd;
  logic [DATA_W-1:0] wr_data;

  assign m_ready = ~hold_full;
  assign m_xfer  = m_valid & m_ready;

  // ALU is the younger producer: a same-index MEM result is dropped outright,
  // and a held entry aimed at the ALU's destination is stale.
  always_comb begin
    wr_src     = SRC_NONE;
    hold_load  = 1'b0;
    hold_drain = 1'b0;
    hold_inval = 1'b0;
    if (a_valid) begin
      wr_src     = SRC_ALU;
      hold_load  = m_xfer && (m_rd != a_rd);
      hold_inval = hold_full && (hold_rd == a_rd);
    end else if (hold_full) begin
      wr_src     = SRC_HOLD;
      hold_drain = 1'b1;
    end else if (m_xfer) begin
      wr_src = SRC_MEM;
    end
  end

  always_comb begin
    wr_en   = 1'b1;
    wr_rd   = a_rd;
    wr_data = a_data;
    case (wr_src)
      SRC_HOLD: begin
        wr_rd   = hold_rd;
        wr_data = hold_data;
      end
      SRC_MEM: begin
        wr_rd   = m_rd;
        wr_data = m_data;
      end
      SRC_ALU:  ;
      default:  wr_en = 1'b0;
    endcase
  end

  wb_hold_buf #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_hold (
    .clk        (clk),
    .rst        (rst),
    .load       (hold_load),
    .load_rd    (m_rd),
    .load_data  (m_data),
    .drain      (hold_drain),
    .invalidate (hold_inval),
    .full       (hold_full),
    .rd         (hold_rd),
    .data       (hold_data)
  );

  // Out-of-range indices never match any slot, so they are ignored for free.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    localparam logic [ADDR_W-1:0] IDX     = ADDR_W'(gi);
    localparam bit                IS_ZERO = (ZERO_REG != 0) && (gi == ZERO_IDX);

    logic [DATA_W-1:0] reg_q, reg_d;
    logic              busy_q, busy_d;
    logic              wr_hit, iss_hit;

    assign wr_hit  = wr_en && (wr_rd == IDX);
    assign iss_hit = iss_valid && (iss_rd == IDX);

    always_comb begin
      reg_d  = reg_q;
      busy_d = busy_q;
      if (IS_ZERO) begin
        reg_d  = '0;
        busy_d = 1'b0;
      end else begin
        if (wr_hit) begin
          reg_d  = wr_data;
          busy_d = 1'b0;
        end
        if (iss_hit) begin
          busy_d = 1'b1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        reg_q  <= '0;
        busy_q <= 1'b0;
      end else begin
        reg_q  <= reg_d;
        busy_q <= busy_d;
      end
    end

    assign regs[gi*DATA_W +: DATA_W] = reg_q;
    assign busy[gi]                  = busy_q;
  end

endmodule
